// File: rtl/accum_dump_pkg.sv
// Shared types and default widths for the accum_dump integrate-and-dump stage.
package accum_dump_pkg;

  // IDLE: nothing accumulated yet; ACCUM: a block is partially summed.
  typedef enum logic {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } state_t;

  // Defaults match the piped_adder output: 4-bit args plus log2(16) growth.
  localparam int unsigned DEF_IN_WIDTH  = 8;
  localparam int unsigned DEF_LEN_WIDTH = 10;

  // Output width that can hold the largest possible block total without overflow.
  function automatic int unsigned min_out_width(input int unsigned iw, input int unsigned lw);
    return iw + lw;
  endfunction

endpackage

// File: rtl/accum_dump_if.sv
// Sample stream, block control and dump result bundle for accum_dump.
interface accum_dump_if
  import accum_dump_pkg::*;
#(
  parameter int unsigned in_width  = DEF_IN_WIDTH,
  parameter int unsigned len_width = DEF_LEN_WIDTH,
  parameter int unsigned out_width = min_out_width(in_width, len_width)
);

  logic signed [in_width-1:0]  sum_in;
  logic                        we;
  logic        [len_width-1:0] len;
  logic                        clear;
  logic signed [out_width-1:0] acc_out;
  logic                        valid;
  logic                        busy;

  // The producer side drives samples and block control, and observes the dump.
  modport master (
    output sum_in, we, len, clear,
    input  acc_out, valid, busy
  );

  // The accumulator side consumes samples and produces the dump.
  modport slave (
    input  sum_in, we, len, clear,
    output acc_out, valid, busy
  );

endinterface

// File: rtl/accum_dump_counter.sv
// Block sequencer for accum_dump: latches the block length, counts accepted
// samples and flags the sample that completes the block.
module accum_dump_counter
  import accum_dump_pkg::*;
#(
  parameter int unsigned len_width = DEF_LEN_WIDTH
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 we,
  input  logic                 clear,
  input  logic [len_width-1:0] len,
  output logic                 accept,
  output logic                 last,
  output logic                 busy
);

  state_t               state_q, state_d;
  logic [len_width-1:0] cnt_q, cnt_d;
  logic [len_width-1:0] len_q, len_d;
  logic [len_width-1:0] eff_len;
  logic [len_width-1:0] cnt_inc;

  // Length in force is the live port before a block starts, the latched one inside it.
  always_comb begin
    eff_len = (state_q == IDLE) ? len : len_q;
    cnt_inc = cnt_q + len_width'(1);
    accept  = we && !clear && (eff_len != '0);
    last    = accept && (cnt_inc == eff_len);
  end

  // Next state: clear aborts, the closing sample returns to IDLE, others advance the count.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    if (clear) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else if (accept) begin
      if (state_q == IDLE) begin
        len_d = len;
      end
      if (last) begin
        state_d = IDLE;
        cnt_d   = '0;
      end else begin
        state_d = ACCUM;
        cnt_d   = cnt_inc;
      end
    end
  end

  // Sequencer registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      len_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
    end
  end

  assign busy = (state_q == ACCUM);

endmodule

// File: rtl/accum_dump.sv
// Integrate-and-dump: sums a programmable number of valid samples and emits
// the block total with a one-cycle valid pulse, restarting without gaps.
// out_width must be at least in_width + len_width so the sum cannot overflow.
module accum_dump
  import accum_dump_pkg::*;
#(
  parameter int unsigned in_width  = DEF_IN_WIDTH,
  parameter int unsigned len_width = DEF_LEN_WIDTH,
  parameter int unsigned out_width = min_out_width(in_width, len_width)
) (
  input  logic         clk,
  input  logic         reset,
  accum_dump_if.slave  bus
);

  logic                        accept;
  logic                        last;
  logic                        busy;
  logic signed [out_width-1:0] sample_ext;
  logic signed [out_width-1:0] sum_next;
  logic signed [out_width-1:0] acc_q, acc_d;
  logic signed [out_width-1:0] acc_out_q, acc_out_d;
  logic                        valid_q, valid_d;

  accum_dump_counter #(
    .len_width (len_width)
  ) u_counter (
    .clk    (clk),
    .reset  (reset),
    .we     (bus.we),
    .clear  (bus.clear),
    .len    (bus.len),
    .accept (accept),
    .last   (last),
    .busy   (busy)
  );

  // Sign-extend the incoming sample and form the running sum including it.
  always_comb begin
    sample_ext = {{(out_width - in_width){bus.sum_in[in_width-1]}}, bus.sum_in};
    sum_next   = acc_q + sample_ext;
  end

  // Datapath: accumulate, dump on the closing sample, discard the partial sum on clear.
  always_comb begin
    acc_d     = acc_q;
    acc_out_d = acc_out_q;
    valid_d   = 1'b0;
    if (bus.clear) begin
      acc_d = '0;
    end else if (accept) begin
      if (last) begin
        acc_out_d = sum_next;
        valid_d   = 1'b1;
        acc_d     = '0;
      end else begin
        acc_d = sum_next;
      end
    end
  end

  // Datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q     <= '0;
      acc_out_q <= '0;
      valid_q   <= 1'b0;
    end else begin
      acc_q     <= acc_d;
      acc_out_q <= acc_out_d;
      valid_q   <= valid_d;
    end
  end

  assign bus.acc_out = acc_out_q;
  assign bus.valid   = valid_q;
  assign bus.busy    = busy;

endmodule

// File: tb/tb_accum_dump.sv
// Testbench for accum_dump: directed scenarios plus randomized traffic, all
// checked against a queue-based block model kept in this file.
module tb_accum_dump;

  localparam int IW = 8;
  localparam int LW = 10;
  localparam int OW = IW + LW;

  logic clk = 1'b0;
  logic reset;

  accum_dump_if #(.in_width(IW), .len_width(LW), .out_width(OW)) bus ();

  accum_dump #(
    .in_width  (IW),
    .len_width (LW),
    .out_width (OW)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Free-running clock, period 10.
  always #5 clk = ~clk;

  // Reference model: the samples of the open block live in a queue; when the
  // queue reaches the block length its arithmetic sum is the dump value.
  int                   blk[$];
  int                   blk_len = 0;
  logic signed [OW-1:0] exp_acc = '0;
  logic                 exp_valid = 1'b0;
  int                   errors = 0;
  int                   checks = 0;

  // Drive one cycle of inputs at the falling edge, advance the model on the
  // rising edge, and return 1 time unit later so outputs can be sampled.
  task automatic step(input logic w, input int s, input int l, input logic c, input logic r);
    int     eff;
    longint tot;
    @(negedge clk);
    bus.we     = w;
    bus.sum_in = s[IW-1:0];
    bus.len    = l[LW-1:0];
    bus.clear  = c;
    reset      = r;
    @(posedge clk);
    exp_valid = 1'b0;
    if (r) begin
      blk.delete();
      blk_len = 0;
      exp_acc = '0;
    end else if (c) begin
      blk.delete();
    end else begin
      eff = (blk.size() == 0) ? l : blk_len;
      if (w && eff != 0) begin
        if (blk.size() == 0) blk_len = l;
        blk.push_back(s);
        if (blk.size() == blk_len) begin
          tot = 0;
          foreach (blk[k]) tot += blk[k];
          exp_acc   = tot[OW-1:0];
          exp_valid = 1'b1;
          blk.delete();
        end
      end
    end
    #1;
  endtask

  // Reset forces every output to zero and the block to idle.
  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 100, 4, 1'b0, 1'b1);
      checks += 3;
      if (bus.acc_out !== '0) begin errors++; $display("[TB] FAIL reset acc_out: got %0d expected 0", bus.acc_out); end
      if (bus.valid !== 1'b0) begin errors++; $display("[TB] FAIL reset valid: got %b expected 0", bus.valid); end
      if (bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL reset busy: got %b expected 0", bus.busy); end
    end
    step(1'b0, 0, 4, 1'b0, 1'b0);
  endtask

  // len=4 with samples 1..4 gives one pulse of 10, busy dropping on the same edge.
  task automatic test_basic();
    int pulses = 0;
    logic signed [OW-1:0] pv = '0;
    for (int i = 0; i < 4; i++) begin
      step(1'b1, i + 1, 4, 1'b0, 1'b0);
      checks += 3;
      if (bus.valid !== exp_valid) begin errors++; $display("[TB] FAIL basic valid[%0d]: got %b expected %b", i, bus.valid, exp_valid); end
      if (bus.acc_out !== exp_acc) begin errors++; $display("[TB] FAIL basic acc_out[%0d]: got %0d expected %0d", i, bus.acc_out, exp_acc); end
      if (bus.busy !== (blk.size() != 0)) begin errors++; $display("[TB] FAIL basic busy[%0d]: got %b expected %b", i, bus.busy, blk.size() != 0); end
      if (bus.valid === 1'b1) begin pulses++; pv = bus.acc_out; end
    end
    checks += 3;
    if (pulses != 1) begin errors++; $display("[TB] FAIL basic pulse count: got %0d expected 1", pulses); end
    if (pv !== OW'(10)) begin errors++; $display("[TB] FAIL basic total: got %0d expected 10", pv); end
    if (bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL basic busy at dump: got %b expected 0", bus.busy); end
    step(1'b0, 0, 4, 1'b0, 1'b0);
  endtask

  // len=3, six back-to-back samples of -128: two dumps of -384, three cycles apart.
  task automatic test_back_to_back();
    int pulse_at[$];
    logic signed [OW-1:0] want = -OW'(384);
    for (int i = 0; i < 6; i++) begin
      step(1'b1, -128, 3, 1'b0, 1'b0);
      checks += 3;
      if (bus.valid !== exp_valid) begin errors++; $display("[TB] FAIL b2b valid[%0d]: got %b expected %b", i, bus.valid, exp_valid); end
      if (bus.acc_out !== exp_acc) begin errors++; $display("[TB] FAIL b2b acc_out[%0d]: got %0d expected %0d", i, bus.acc_out, exp_acc); end
      if (bus.busy !== (blk.size() != 0)) begin errors++; $display("[TB] FAIL b2b busy[%0d]: got %b expected %b", i, bus.busy, blk.size() != 0); end
      if (bus.valid === 1'b1) begin
        pulse_at.push_back(i);
        checks++;
        if (bus.acc_out !== want) begin errors++; $display("[TB] FAIL b2b total: got %0d expected -384", bus.acc_out); end
      end
    end
    checks++;
    if (pulse_at.size() != 2 || pulse_at[1] - pulse_at[0] != 3) begin
      errors++; $display("[TB] FAIL b2b spacing: got %0d pulses expected 2 three cycles apart", pulse_at.size());
    end
    step(1'b0, 0, 3, 1'b0, 1'b0);
  endtask

  // len=1 dumps every sample, so valid stays high across consecutive samples.
  task automatic test_len_one();
    int vals[3] = '{-5, 7, 0};
    logic signed [OW-1:0] want;
    for (int i = 0; i < 3; i++) begin
      step(1'b1, vals[i], 1, 1'b0, 1'b0);
      want = OW'(vals[i]);
      checks += 4;
      if (bus.valid !== 1'b1) begin errors++; $display("[TB] FAIL len1 valid[%0d]: got %b expected 1", i, bus.valid); end
      if (bus.acc_out !== want) begin errors++; $display("[TB] FAIL len1 acc_out[%0d]: got %0d expected %0d", i, bus.acc_out, want); end
      if (bus.acc_out !== exp_acc) begin errors++; $display("[TB] FAIL len1 model acc_out[%0d]: got %0d expected %0d", i, bus.acc_out, exp_acc); end
      if (bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL len1 busy[%0d]: got %b expected 0", i, bus.busy); end
    end
    step(1'b0, 0, 1, 1'b0, 1'b0);
  endtask

  // A len change mid-block is ignored until the next block starts.
  task automatic test_len_change();
    logic w_a[9] = '{1, 1, 0, 1, 0, 0, 0, 1, 1};
    int   s_a[9] = '{10, 20, 0, 30, 0, 0, 0, 40, 3};
    int   l_a[9] = '{4, 4, 2, 2, 2, 2, 2, 2, 2};
    logic signed [OW-1:0] pv[$];
    for (int i = 0; i < 9; i++) begin
      step(w_a[i], s_a[i], l_a[i], 1'b0, 1'b0);
      checks += 3;
      if (bus.valid !== exp_valid) begin errors++; $display("[TB] FAIL lenchg valid[%0d]: got %b expected %b", i, bus.valid, exp_valid); end
      if (bus.acc_out !== exp_acc) begin errors++; $display("[TB] FAIL lenchg acc_out[%0d]: got %0d expected %0d", i, bus.acc_out, exp_acc); end
      if (bus.busy !== (blk.size() != 0)) begin errors++; $display("[TB] FAIL lenchg busy[%0d]: got %b expected %b", i, bus.busy, blk.size() != 0); end
      if (bus.valid === 1'b1) pv.push_back(bus.acc_out);
    end
    step(1'b1, 4, 9, 1'b0, 1'b0);
    if (bus.valid === 1'b1) pv.push_back(bus.acc_out);
    checks += 2;
    if (pv.size() != 2) begin
      errors++; $display("[TB] FAIL lenchg pulse count: got %0d expected 2", pv.size());
    end else begin
      if (pv[0] !== OW'(100) || pv[1] !== OW'(7)) begin
        errors++; $display("[TB] FAIL lenchg totals: got %0d,%0d expected 100,7", pv[0], pv[1]);
      end
    end
    if (bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL lenchg busy after len2 block: got %b expected 0", bus.busy); end
  endtask

  // Clear with a coincident sample drops both; acc_out holds until the next dump.
  task automatic test_clear();
    logic w_a[7] = '{1, 1, 1, 1, 1, 1, 1};
    int   s_a[7] = '{5, 5, 5, 1, 1, 1, 1};
    logic c_a[7] = '{0, 0, 1, 0, 0, 0, 0};
    logic signed [OW-1:0] held;
    int pulses = 0;
    held = bus.acc_out;
    for (int i = 0; i < 7; i++) begin
      step(w_a[i], s_a[i], 4, c_a[i], 1'b0);
      checks += 3;
      if (bus.valid !== exp_valid) begin errors++; $display("[TB] FAIL clear valid[%0d]: got %b expected %b", i, bus.valid, exp_valid); end
      if (bus.acc_out !== exp_acc) begin errors++; $display("[TB] FAIL clear acc_out[%0d]: got %0d expected %0d", i, bus.acc_out, exp_acc); end
      if (bus.busy !== (blk.size() != 0)) begin errors++; $display("[TB] FAIL clear busy[%0d]: got %b expected %b", i, bus.busy, blk.size() != 0); end
      if (i < 6) begin
        checks++;
        if (bus.acc_out !== held) begin errors++; $display("[TB] FAIL clear hold[%0d]: got %0d expected %0d", i, bus.acc_out, held); end
      end
      if (bus.valid === 1'b1) pulses++;
    end
    checks += 2;
    if (pulses != 1) begin errors++; $display("[TB] FAIL clear pulse count: got %0d expected 1", pulses); end
    if (bus.acc_out !== OW'(4)) begin errors++; $display("[TB] FAIL clear total: got %0d expected 4", bus.acc_out); end
  endtask

  // Reset mid-block loses the partial sum; len=0 ignores samples entirely.
  task automatic test_reset_mid();
    int pulses = 0;
    step(1'b1, 9, 4, 1'b0, 1'b0);
    step(1'b1, 9, 4, 1'b0, 1'b0);
    step(1'b1, 9, 4, 1'b0, 1'b1);
    checks += 3;
    if (bus.acc_out !== '0) begin errors++; $display("[TB] FAIL rstmid acc_out: got %0d expected 0", bus.acc_out); end
    if (bus.valid !== 1'b0) begin errors++; $display("[TB] FAIL rstmid valid: got %b expected 0", bus.valid); end
    if (bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL rstmid busy: got %b expected 0", bus.busy); end
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 2, 4, 1'b0, 1'b0);
      checks += 2;
      if (bus.valid !== exp_valid) begin errors++; $display("[TB] FAIL rstmid valid[%0d]: got %b expected %b", i, bus.valid, exp_valid); end
      if (bus.acc_out !== exp_acc) begin errors++; $display("[TB] FAIL rstmid acc_out[%0d]: got %0d expected %0d", i, bus.acc_out, exp_acc); end
      if (bus.valid === 1'b1) pulses++;
    end
    checks += 2;
    if (pulses != 1) begin errors++; $display("[TB] FAIL rstmid pulse count: got %0d expected 1", pulses); end
    if (bus.acc_out !== OW'(8)) begin errors++; $display("[TB] FAIL rstmid total: got %0d expected 8", bus.acc_out); end
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 5, 0, 1'b0, 1'b0);
      checks += 2;
      if (bus.valid !== 1'b0) begin errors++; $display("[TB] FAIL len0 valid[%0d]: got %b expected 0", i, bus.valid); end
      if (bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL len0 busy[%0d]: got %b expected 0", i, bus.busy); end
    end
  endtask

  // Random samples, gaps, lengths, clears and occasional resets against the model.
  task automatic test_random();
    logic w, c, r;
    int   s, l;
    for (int i = 0; i < 600; i++) begin
      w = ($urandom_range(0, 3) != 0);
      s = int'($urandom_range(0, 255)) - 128;
      l = int'($urandom_range(0, 5));
      c = ($urandom_range(0, 24) == 0);
      r = ($urandom_range(0, 99) == 0);
      step(w, s, l, c, r);
      checks += 3;
      if (bus.valid !== exp_valid) begin errors++; $display("[TB] FAIL rand valid[%0d]: got %b expected %b", i, bus.valid, exp_valid); end
      if (bus.acc_out !== exp_acc) begin errors++; $display("[TB] FAIL rand acc_out[%0d]: got %0d expected %0d", i, bus.acc_out, exp_acc); end
      if (bus.busy !== (blk.size() != 0)) begin errors++; $display("[TB] FAIL rand busy[%0d]: got %b expected %b", i, bus.busy, blk.size() != 0); end
    end
  endtask

  // Run every scenario in order, then print the summary.
  initial begin
    reset      = 1'b1;
    bus.we     = 1'b0;
    bus.sum_in = '0;
    bus.len    = '0;
    bus.clear  = 1'b0;
    test_reset();
    test_basic();
    test_back_to_back();
    test_len_one();
    test_len_change();
    test_clear();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
